// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the fixed-latency data memory (pipeline port A, loader port B).
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_rd,
    input  logic              a_wr,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_err,
    output logic              freeze,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [31:0]       b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_ack,
    output logic [31:0]       b_rdata,
    output logic              b_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       b_grant_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    localparam logic       OWN_A    = 1'b0;
    localparam logic       OWN_B    = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    // Offset must be word aligned and fall inside the 2^ADDR_W-word segment.
    function automatic logic addr_ok(input logic [31:0] off);
        addr_ok = (off[1:0] == 2'b00) && ((off >> (ADDR_W + 2)) == 32'd0);
    endfunction

    state_t            state_r;
    logic              owner_r;
    logic              last_grant_r;
    logic              we_r;
    logic              err_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] idx_r;
    logic [31:0]       wdata_r;
    logic [31:0]       a_rdata_r;
    logic [31:0]       b_rdata_r;

    logic              a_req_s;
    logic              grant_b_s;
    logic              sel_we_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic [31:0]       off_s;
    logic              sel_ok_s;

    // Round-robin pick and address decode of the candidate request.
    always_comb begin
        a_req_s   = a_rd | a_wr;
        grant_b_s = b_req & (~a_req_s | (last_grant_r == OWN_A));
        if (grant_b_s) begin
            sel_we_s    = b_we;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_we_s    = a_wr;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
        off_s    = sel_addr_s - BASE_ADDR;
        sel_ok_s = addr_ok(off_s);
    end

    // Access sequencer: grant, run the memory cycles, present results for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_r      <= OWN_A;
            last_grant_r <= OWN_B;
            we_r         <= 1'b0;
            err_r        <= 1'b0;
            cnt_r        <= 4'd0;
            idx_r        <= '0;
            wdata_r      <= 32'd0;
            a_rdata_r    <= 32'd0;
            b_rdata_r    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (a_req_s | b_req) begin
                        owner_r      <= grant_b_s;
                        last_grant_r <= grant_b_s;
                        we_r         <= sel_we_s;
                        idx_r        <= off_s[ADDR_W+1:2];
                        wdata_r      <= sel_wdata_s;
                        err_r        <= ~sel_ok_s;
                        cnt_r        <= 4'd0;
                        if (sel_ok_s) begin
                            state_r <= ACCESS;
                        end else begin
                            state_r <= DONE;
                            if (!sel_we_s) begin
                                if (grant_b_s) b_rdata_r <= 32'd0;
                                else           a_rdata_r <= 32'd0;
                            end
                        end
                    end
                end
                ACCESS: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= DONE;
                        if (!we_r) begin
                            if (owner_r == OWN_B) b_rdata_r <= mem_rdata;
                            else                  a_rdata_r <= mem_rdata;
                        end
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign a_rdata   = a_rdata_r;
    assign b_rdata   = b_rdata_r;
    assign a_err     = (state_r == DONE) & (owner_r == OWN_A) & err_r;
    assign b_ack     = (state_r == DONE) & (owner_r == OWN_B);
    assign b_err     = (state_r == DONE) & (owner_r == OWN_B) & err_r;
    assign mem_en    = (state_r == ACCESS);
    assign mem_we    = (state_r == ACCESS) & we_r;
    assign mem_addr  = idx_r;
    assign mem_wdata = wdata_r;
    // Gated by rst so the stall drops the moment reset is asserted.
    assign freeze    = rst & a_req_s & ~((state_r == DONE) & (owner_r == OWN_A));

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] b_grant_cnt_r;
    logic        b_grant_s;

    assign b_grant_s = (state_r == IDLE) & grant_b_s;

    // Saturating stall and port-B grant counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r   <= 16'd0;
            b_grant_cnt_r <= 16'd0;
        end else begin
            if (freeze && (stall_cnt_r != 16'hFFFF)) stall_cnt_r <= stall_cnt_r + 16'd1;
            else                                     stall_cnt_r <= stall_cnt_r;
            if (b_grant_s && (b_grant_cnt_r != 16'hFFFF)) b_grant_cnt_r <= b_grant_cnt_r + 16'd1;
            else                                          b_grant_cnt_r <= b_grant_cnt_r;
        end
    end

    assign stall_cnt   = stall_cnt_r;
    assign b_grant_cnt = b_grant_cnt_r;
`else
    assign stall_cnt   = 16'd0;
    assign b_grant_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single transfers plus round-robin, reset-abort and stats sequences.
module tb_dmem_arbiter;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_rd, a_wr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_err, freeze;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_ack, b_err;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] stall_cnt, b_grant_cnt;

    dmem_arbiter #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .a_rd(a_rd), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_err(a_err), .freeze(freeze),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt), .b_grant_cnt(b_grant_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: a write commits only on the last cycle of a complete access.
    logic [31:0] tb_mem [0:1023];
    int          mcnt;
    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we && mcnt == W - 1) tb_mem[mem_addr] <= mem_wdata;
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
    end

    int tb_stall;
    int tb_bgrant;
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            tb_stall  <= 0;
            tb_bgrant <= 0;
        end else begin
            if (freeze) tb_stall  <= tb_stall + 1;
            if (b_ack)  tb_bgrant <= tb_bgrant + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_b;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          mcyc;
        logic [9:0]  idx;
    } vec_t;

    vec_t vecs[13];
    vec_t sb[$];

    task automatic idle_inputs();
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_wdata = 32'd0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run_xfer(input vec_t v);
        vec_t        e;
        int          lat = -1;
        int          mc = 0;
        int          fc = 0;
        int          stray_we = 0;
        logic        done = 1'b0;
        logic        err_seen = 1'b0;
        logic        we_seen = 1'b0;
        logic [31:0] rd_seen = 32'd0;
        logic [9:0]  idx_seen = 10'd0;
        sb.push_back(v);
        if (v.is_b) begin
            b_req = 1'b1; b_we = v.wr; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_rd = v.rd; a_wr = v.wr; a_addr = v.addr; a_wdata = v.wdata;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_en) begin
                mc++;
                idx_seen = mem_addr;
                we_seen  = mem_we;
            end else if (mem_we) begin
                stray_we++;
            end
            if (freeze) fc++;
            if (!v.is_b && !freeze) begin
                done = 1'b1; lat = c; err_seen = a_err; rd_seen = a_rdata;
            end
            if (v.is_b && b_ack) begin
                done = 1'b1; lat = c; err_seen = b_err; rd_seen = b_rdata;
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        e = sb.pop_front();
        check("xfer_done", 32'(done), 32'd1);
        check("xfer_latency", 32'(lat), 32'(e.lat));
        check("xfer_err", 32'(err_seen), 32'(e.err));
        check("xfer_mem_cycles", 32'(mc), 32'(e.mcyc));
        check("xfer_stray_we", 32'(stray_we), 32'd0);
        check("xfer_freeze_cycles", 32'(fc), e.is_b ? 32'd0 : 32'(e.lat));
        if (mc > 0) begin
            check("xfer_mem_addr", 32'(idx_seen), 32'(e.idx));
            check("xfer_mem_we", 32'(we_seen), 32'(e.wr));
        end
        if (e.rd && !e.wr) check("xfer_rdata", rd_seen, e.rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int aq[$];
        int bq[$];
        int exp_c;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'd0;

        //            is_b  rd    wr    addr           wdata          err   rdata          lat mc idx
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'd1028,      32'hDEADBEEF, 1'b0, 32'd0,         5, 4, 10'd1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd1028,      32'd0,        1'b0, 32'hDEADBEEF,  5, 4, 10'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd1000,      32'd0,        1'b1, 32'd0,         1, 0, 10'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd1026,      32'd0,        1'b1, 32'd0,         1, 0, 10'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd5120,      32'd0,        1'b1, 32'd0,         1, 0, 10'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd5116,      32'h12345678, 1'b0, 32'd0,         5, 4, 10'd1023};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'd5116,      32'd0,        1'b0, 32'h12345678,  5, 4, 10'd1023};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd1024,      32'd0,        1'b0, 32'd0,         5, 4, 10'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'd5120,      32'd0,        1'b1, 32'd0,         1, 0, 10'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'd1032,      32'hCAFEF00D, 1'b0, 32'd0,         5, 4, 10'd2};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd1032,      32'd0,        1'b0, 32'hCAFEF00D,  5, 4, 10'd2};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'd1027,      32'h0BADF00D, 1'b1, 32'd0,         1, 0, 10'd0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFC,  32'd0,        1'b1, 32'd0,         1, 0, 10'd0};

        // Reset state, with requests pending so freeze gating is exercised.
        idle_inputs();
        rst = 1'b0;
        a_rd = 1'b1; a_addr = 32'd1028; b_req = 1'b1; b_addr = 32'd1028;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_mem", {29'd0, mem_en, mem_we, b_ack}, 32'd0);
        check("rst_errs", {30'd0, a_err, b_err}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_mem_bus", {22'd0, mem_addr} | mem_wdata, 32'd0);
        check("rst_stats", {stall_cnt, b_grant_cnt}, 32'd0);
        do_reset();

        for (int i = 0; i < 13; i++) run_xfer(vecs[i]);

        // Round robin from reset: A first (last grant B), then strict alternation.
        do_reset();
        a_rd = 1'b1; a_addr = 32'd1028;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd1032;
        for (int k = 0; k < 8; k++) begin
            aq.push_back(5 + 12 * k);
            bq.push_back(11 + 12 * k);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!freeze) begin
                exp_c = (aq.size() != 0) ? aq.pop_front() : -1;
                check("rr_a_done_cycle", 32'(c), 32'(exp_c));
                check("rr_a_rdata", a_rdata, 32'hDEADBEEF);
            end
            if (b_ack) begin
                exp_c = (bq.size() != 0) ? bq.pop_front() : -1;
                check("rr_b_ack_cycle", 32'(c), 32'(exp_c));
                check("rr_b_rdata", b_rdata, 32'hCAFEF00D);
            end
            @(posedge clk);
            #1;
        end
        check("rr_a_missing", 32'(aq.size()), 32'd0);
        check("rr_b_missing", 32'(bq.size()), 32'd0);

        // Reset during ACCESS (cnt=2) of a B write while A is stalled.
        do_reset();
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd1040; b_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        a_rd = 1'b1; a_addr = 32'd1028;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_pre_mem_en", 32'(mem_en), 32'd1);
        check("abort_pre_freeze", 32'(freeze), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_freeze", 32'(freeze), 32'd0);
        check("abort_b_ack", 32'(b_ack), 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_no_partial_write", tb_mem[4], 32'd0);
        run_xfer('{1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'd0, 5, 4, 10'd4});

        // Statistics after a fresh reset: three B writes and one A read.
        do_reset();
        run_xfer('{1'b1, 1'b0, 1'b1, 32'd1044, 32'h1, 1'b0, 32'd0, 5, 4, 10'd5});
        run_xfer('{1'b1, 1'b0, 1'b1, 32'd1048, 32'h2, 1'b0, 32'd0, 5, 4, 10'd6});
        run_xfer('{1'b1, 1'b0, 1'b1, 32'd1052, 32'h3, 1'b0, 32'd0, 5, 4, 10'd7});
        run_xfer('{1'b0, 1'b1, 1'b0, 32'd1048, 32'd0, 1'b0, 32'h2, 5, 4, 10'd6});
        @(negedge clk);
`ifdef DMEM_ARB_STATS_EN
        check("stats_stall_cnt", 32'(stall_cnt), 32'(tb_stall));
        check("stats_b_grant_cnt", 32'(b_grant_cnt), 32'(tb_bgrant));
`else
        check("stats_stall_cnt", 32'(stall_cnt), 32'd0);
        check("stats_b_grant_cnt", 32'(b_grant_cnt), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
